// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3).
// One accepted request is converted MSB-first over BIN_W shift cycles plus one
// commit cycle. The result is held on bcd_out until the next completion or reset.
module bin2bcd_seq #(
    parameter int BIN_W   = 20,
    parameter int DIGITS  = 6,
    parameter int MAX_VAL = 999_999
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  conv_req,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  bcd_valid,
    output logic                  ovf
);

    localparam int               BCD_W = 4 * DIGITS;
    localparam int               CNT_W = $clog2(BIN_W + 1);
    localparam logic [BIN_W-1:0] MAX_V = BIN_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [BIN_W-1:0] src;
    logic [BCD_W-1:0] scratch;
    logic [BCD_W-1:0] scr_adj;
    logic [CNT_W-1:0] cnt;
    logic             ovf_i;

    // Per-digit add-3 correction; each nibble is adjusted on its own, no carry
    // crosses a nibble boundary.
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        assign scr_adj[4*d +: 4] = (scratch[4*d +: 4] >= 4'd5) ? scratch[4*d +: 4] + 4'd3
                                                               : scratch[4*d +: 4];
    end

    // Control FSM, datapath and registered outputs.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            src       <= '0;
            scratch   <= '0;
            cnt       <= '0;
            ovf_i     <= 1'b0;
            busy      <= 1'b0;
            bcd_out   <= '0;
            bcd_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (conv_req) begin
                        // Out-of-range values saturate so the display never
                        // needs more than DIGITS digits.
                        src     <= (bin_in > MAX_V) ? MAX_V : bin_in;
                        ovf_i   <= (bin_in > MAX_V);
                        scratch <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Adjust then shift {scratch,src} left by one in a single step.
                    scratch <= {scr_adj[BCD_W-2:0], src[BIN_W-1]};
                    src     <= {src[BIN_W-2:0], 1'b0};
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) state <= DONE;
                end
                DONE: begin
                    bcd_out   <= scratch;
                    ovf       <= ovf_i;
                    bcd_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: reset state, table of fixed vectors,
// held-request throughput, mid-conversion reset and random values against a
// divide/mod-10 reference model.
module tb_bin2bcd_seq;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic [19:0] bin_in  = '0;
    logic        conv_req = 1'b0;
    logic        busy;
    logic [23:0] bcd_out;
    logic        bcd_valid;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    bin2bcd_seq dut (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .bin_in   (bin_in),
        .conv_req (conv_req),
        .busy     (busy),
        .bcd_out  (bcd_out),
        .bcd_valid(bcd_valid),
        .ovf      (ovf)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [19:0] bin;
        logic [23:0] bcd;
        logic        ovf;
    } vec_t;

    // Reference: saturate, then peel decimal digits with plain arithmetic.
    function automatic logic [24:0] model(input logic [19:0] v);
        int          x;
        logic        o;
        logic [23:0] b;
        x = int'(v);
        o = (x > 999999);
        if (o) x = 999999;
        b = '0;
        for (int i = 0; i < 6; i++) begin
            b[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return {o, b};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue a one-cycle request and check latency, busy span, result and pulse width.
    task automatic run_conv(input logic [19:0] v, input logic [23:0] exp_bcd,
                            input logic exp_ovf, input string nm);
        int n;
        int bc;
        @(negedge sys_clk);
        bin_in   = v;
        conv_req = 1'b1;
        @(negedge sys_clk);
        conv_req = 1'b0;
        bin_in   = 20'($urandom);
        n  = 1;
        bc = 0;
        while (!bcd_valid && n < 60) begin
            if (busy) bc++;
            @(negedge sys_clk);
            n++;
        end
        chk({nm, " latency"}, n, 22);
        chk({nm, " busy_cycles"}, bc, 21);
        chk({nm, " busy_at_valid"}, {31'd0, busy}, 0);
        chk({nm, " bcd"}, {8'd0, bcd_out}, {8'd0, exp_bcd});
        chk({nm, " ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
        @(negedge sys_clk);
        chk({nm, " valid_pulse"}, {31'd0, bcd_valid}, 0);
    endtask

    vec_t        vecs[7];
    logic [19:0] hist[$];
    logic [24:0] m;
    int          nv;

    initial begin
        vecs[0] = '{20'd123456,  24'h123456, 1'b0};
        vecs[1] = '{20'd0,       24'h000000, 1'b0};
        vecs[2] = '{20'd999999,  24'h999999, 1'b0};
        vecs[3] = '{20'd9,       24'h000009, 1'b0};
        vecs[4] = '{20'hFFFFF,   24'h999999, 1'b1};
        vecs[5] = '{20'd1000000, 24'h999999, 1'b1};
        vecs[6] = '{20'd42,      24'h000042, 1'b0};

        // Reset state
        repeat (3) @(negedge sys_clk);
        chk("rst busy", {31'd0, busy}, 0);
        chk("rst valid", {31'd0, bcd_valid}, 0);
        chk("rst bcd", {8'd0, bcd_out}, 0);
        chk("rst ovf", {31'd0, ovf}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        chk("idle valid", {31'd0, bcd_valid}, 0);

        // Fixed vectors (T1..T3)
        foreach (vecs[i]) run_conv(vecs[i].bin, vecs[i].bcd, vecs[i].ovf, $sformatf("vec%0d", i));

        // Held request, bin_in changing every cycle: accepts at j = 0, 22, 44, 66
        for (int j = 0; j <= 66; j++) begin
            @(negedge sys_clk);
            if (j > 0) begin
                if (j % 22 == 0) begin
                    m = model(hist[j-22]);
                    chk($sformatf("held valid j%0d", j), {31'd0, bcd_valid}, 1);
                    chk($sformatf("held bcd j%0d", j), {8'd0, bcd_out}, {8'd0, m[23:0]});
                    chk($sformatf("held ovf j%0d", j), {31'd0, ovf}, {31'd0, m[24]});
                end else if (bcd_valid) begin
                    chk($sformatf("held stray valid j%0d", j), 1, 0);
                end
            end
            bin_in   = 20'($urandom);
            conv_req = 1'b1;
            hist.push_back(bin_in);
        end
        @(negedge sys_clk);
        conv_req = 1'b0;
        repeat (30) @(negedge sys_clk);

        // Reset at the 10th shift edge aborts the conversion silently
        @(negedge sys_clk);
        bin_in   = 20'd654321;
        conv_req = 1'b1;
        @(negedge sys_clk);
        conv_req = 1'b0;
        repeat (9) @(negedge sys_clk);
        rst_n = 1'b0;
        @(negedge sys_clk);
        rst_n = 1'b1;
        chk("abort busy", {31'd0, busy}, 0);
        chk("abort bcd", {8'd0, bcd_out}, 0);
        chk("abort ovf", {31'd0, ovf}, 0);
        nv = 0;
        repeat (30) begin
            if (bcd_valid) nv++;
            @(negedge sys_clk);
        end
        chk("abort no_valid", nv, 0);
        run_conv(20'd7, 24'h000007, 1'b0, "after_abort");

        // Random values against the reference model
        for (int k = 0; k < 1000; k++) begin
            logic [19:0] r;
            r = 20'($urandom);
            m = model(r);
            run_conv(r, m[23:0], m[24], $sformatf("rand%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
